ball_motion: RTL
================

Name: ball_motion

Overview:
- Per-ball kinematics stage directly downstream of the ball-ball collision stage: owns one ball's position and velocity.
- Integrates position once per frame in sub-pixel fixed point and applies per-frame friction toward zero.
- Loads new velocity on a collision pulse, a cue strike, or a wall hit (reflection).
- Outputs feed the object drawer (top-left position) and loop back into the collision stage (current velocity).

Parameters:
- FRAC_BITS, 6: fractional bits of position; velocity unit is 1/2^FRAC_BITS px per frame.
- FRICTION, 2: magnitude subtracted from each nonzero velocity component per frame.
- MAX_SPEED, 960: saturation bound on each velocity component, absolute value, in velocity units.
- X_MIN, 32 / X_MAX, 576: legal top-left X range in pixels, inclusive.
- Y_MIN, 32 / Y_MAX, 416: legal top-left Y range in pixels, inclusive.
- INIT_X, 288 / INIT_Y, 224: reset position in pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse once per video frame.
- collisionOccurred  in  1  one-cycle pulse from the collision stage.
- ballVelXIn / ballVelYIn  in  11 signed  post-collision velocity; sampled only when collisionOccurred=1.
- strikeValid  in  1  one-cycle cue-strike request.
- strikeVelX / strikeVelY  in  11 signed  strike velocity.
- hitLeft / hitRight / hitTop / hitBottom  in  1  wall/cushion contact flags from the border hit detector; may be level for several cycles.
- topLeftX / topLeftY  out  11  integer-pixel position (internal position >> FRAC_BITS).
- ballVelX / ballVelY  out  11 signed  current velocity.
- moving  out  1  1 when state is MOVING.
- strikeAccepted  out  1  one-cycle pulse when a strike is taken.

Behaviour:
- Reset (async, active-high): position = INIT_X/INIT_Y << FRAC_BITS; velocity 0; state STOPPED; moving=0; strikeAccepted=0.
- States:
  - STOPPED: velocity is zero.
    - strikeValid=1 -> load strike velocity (saturated to ±MAX_SPEED), pulse strikeAccepted next cycle, go to MOVING.
    - collisionOccurred=1 with nonzero input velocity -> load it, go to MOVING.
  - MOVING: strikeValid is ignored (no pulse). Go to STOPPED on the cycle that both velocity components become 0.
- Per-cycle event priority within MOVING: collision > wall reflection > frame update.
  - Collision: velocity := saturate(ballVelXIn/YIn), registered, 1-cycle latency. Any wall flip requested in the same cycle is dropped.
  - Wall reflection: hitLeft with ballVelX<0 -> negate X; hitRight with ballVelX>0 -> negate X; Y likewise with hitTop/hitBottom.
    - The sign qualification makes a level-held hit flip exactly once.
    - Negating −1024 is impossible because saturation guarantees |v| ≤ MAX_SPEED.
  - Frame update (startOfFrame=1):
    - pos += sign-extended velocity. Velocity used is the one loaded this cycle if a collision coincides; friction is skipped that frame.
    - Clamp the result to [MIN<<FRAC_BITS, MAX<<FRAC_BITS].
    - Otherwise friction per component: |v| ≤ FRICTION -> 0, else v −= sign(v)·FRICTION.
- Wall flip and startOfFrame in the same cycle: flip first, then integrate with the flipped velocity, then apply friction.
- Outputs are registered; a change from any event is visible the cycle after the triggering input.
- Internal arithmetic: position 11+FRAC_BITS bits unsigned, with a one-bit-wider signed intermediate for the add and clamp. Velocity sums use 12-bit signed before saturation.
- startOfFrame in STOPPED: no position change.

Decomposition:
- Package billiard_pkg: FRAC_BITS, VEL_W=11, POS_W=11, playfield bounds, typedef ball_state_t {STOPPED, MOVING}, function sat_vel().
- Sub-module vel_friction: combinational one-component friction and saturate; instanced twice.

Test Plan:
- Reset mid-motion: assert reset while MOVING with vel (100,−50) -> same edge topLeft=(288,224), vel 0, moving=0.
- Strike then frames: strike (128,64) in STOPPED -> strikeAccepted pulse. After 1 frame pos X=288+2=290, Y=225; vel (126,62).
- Friction to stop: vel (3,−1), FRICTION=2 -> after frame 1 vel (1,0). After frame 2 vel (0,0), moving falls; position stays fixed on later frames.
- Wall hit held: vel (−200,0), hitLeft held 5 cycles -> X velocity becomes +200 exactly once, not re-flipped.
- Collision + startOfFrame same cycle: ballVelXIn=300 -> vel 300 with no friction; pos X advances by 300>>6 integer px, fractional part carried.
- Saturation and clamp: strike (1023,0) -> vel 960. Position near X_MAX clamps at 576, never exceeds it.
- Strike while MOVING -> ignored, no strikeAccepted pulse.

Source files
------------

// File: rtl/ball_motion_pkg.sv
// Shared constants, state type and velocity saturation helper for the billiard ball pipeline.
package billiard_pkg;
    localparam int FRAC_BITS = 6;
    localparam int VEL_W     = 11;
    localparam int POS_W     = 11;
    localparam int PFX_W     = POS_W + FRAC_BITS;

    localparam int FRICTION_DEF  = 2;
    localparam int MAX_SPEED_DEF = 960;
    localparam int X_MIN_DEF     = 32;
    localparam int X_MAX_DEF     = 576;
    localparam int Y_MIN_DEF     = 32;
    localparam int Y_MAX_DEF     = 416;
    localparam int INIT_X_DEF    = 288;
    localparam int INIT_Y_DEF    = 224;

    typedef enum logic {STOPPED, MOVING} ball_state_t;

    // Clamp a one-bit-wide velocity sum to +/-max_speed.
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W:0] v,
                                                        input int max_speed);
        if (v > max_speed)
            return VEL_W'(max_speed);
        else if (v < -max_speed)
            return VEL_W'(-max_speed);
        else
            return v[VEL_W-1:0];
    endfunction
endpackage

// File: rtl/ball_motion_if.sv
// Event inputs and position/velocity outputs of one ball's kinematics stage.
interface ball_motion_if;
    import billiard_pkg::*;

    logic                    startOfFrame;
    logic                    collisionOccurred;
    logic signed [VEL_W-1:0] ballVelXIn;
    logic signed [VEL_W-1:0] ballVelYIn;
    logic                    strikeValid;
    logic signed [VEL_W-1:0] strikeVelX;
    logic signed [VEL_W-1:0] strikeVelY;
    logic                    hitLeft;
    logic                    hitRight;
    logic                    hitTop;
    logic                    hitBottom;
    logic [POS_W-1:0]        topLeftX;
    logic [POS_W-1:0]        topLeftY;
    logic signed [VEL_W-1:0] ballVelX;
    logic signed [VEL_W-1:0] ballVelY;
    logic                    moving;
    logic                    strikeAccepted;

    modport slave (
        input  startOfFrame, collisionOccurred, ballVelXIn, ballVelYIn,
               strikeValid, strikeVelX, strikeVelY,
               hitLeft, hitRight, hitTop, hitBottom,
        output topLeftX, topLeftY, ballVelX, ballVelY, moving, strikeAccepted
    );

    modport master (
        output startOfFrame, collisionOccurred, ballVelXIn, ballVelYIn,
               strikeValid, strikeVelX, strikeVelY,
               hitLeft, hitRight, hitTop, hitBottom,
        input  topLeftX, topLeftY, ballVelX, ballVelY, moving, strikeAccepted
    );
endinterface

// File: rtl/ball_motion_vel_friction.sv
// One velocity component: optional friction toward zero, then saturation.
module vel_friction
    import billiard_pkg::*;
#(
    parameter int FRICTION  = FRICTION_DEF,
    parameter int MAX_SPEED = MAX_SPEED_DEF
) (
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic                    fric_en_i,
    output logic signed [VEL_W-1:0] vel_o
);
    logic signed [VEL_W:0] ext;
    logic signed [VEL_W:0] sum;

    always_comb begin
        ext = {vel_i[VEL_W-1], vel_i};
        sum = ext;
        if (fric_en_i) begin
            // Speeds at or below the friction step snap to zero rather than overshoot.
            if (ext > FRICTION)
                sum = ext - $signed((VEL_W+1)'(FRICTION));
            else if (ext < -FRICTION)
                sum = ext + $signed((VEL_W+1)'(FRICTION));
            else
                sum = '0;
        end
        vel_o = sat_vel(sum, MAX_SPEED);
    end
endmodule

// File: rtl/ball_motion.sv
// Single-ball kinematics: sub-pixel position integration, friction, wall reflection,
// collision/strike velocity loads.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int FRICTION  = FRICTION_DEF,
    parameter int MAX_SPEED = MAX_SPEED_DEF,
    parameter int X_MIN     = X_MIN_DEF,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_MIN     = Y_MIN_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int INIT_X    = INIT_X_DEF,
    parameter int INIT_Y    = INIT_Y_DEF
) (
    input logic          clk,
    input logic          reset,
    ball_motion_if.slave bus
);
    ball_state_t             state_q, state_d;
    logic [PFX_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                    acc_q, acc_d;

    logic signed [VEL_W-1:0] col_x, col_y, strk_x, strk_y;
    logic signed [VEL_W-1:0] flip_x, flip_y, fr_x, fr_y, int_vx, int_vy;
    logic [PFX_W-1:0]        nx_pos_x, nx_pos_y;

    // Add signed velocity to unsigned sub-pixel position, clamp to the legal range.
    function automatic logic [PFX_W-1:0] integ(input logic [PFX_W-1:0] p,
                                               input logic signed [VEL_W-1:0] v,
                                               input int lo_px, input int hi_px);
        logic signed [PFX_W:0] s;
        s = $signed({1'b0, p}) + $signed({{(PFX_W+1-VEL_W){v[VEL_W-1]}}, v});
        if (s < (lo_px << FRAC_BITS))
            return PFX_W'(lo_px << FRAC_BITS);
        else if (s > (hi_px << FRAC_BITS))
            return PFX_W'(hi_px << FRAC_BITS);
        else
            return s[PFX_W-1:0];
    endfunction

    always_comb begin
        col_x  = sat_vel({bus.ballVelXIn[VEL_W-1], bus.ballVelXIn}, MAX_SPEED);
        col_y  = sat_vel({bus.ballVelYIn[VEL_W-1], bus.ballVelYIn}, MAX_SPEED);
        strk_x = sat_vel({bus.strikeVelX[VEL_W-1], bus.strikeVelX}, MAX_SPEED);
        strk_y = sat_vel({bus.strikeVelY[VEL_W-1], bus.strikeVelY}, MAX_SPEED);

        // Sign qualification makes a level-held contact flip only once.
        flip_x = vel_x_q;
        if ((bus.hitLeft && vel_x_q < 0) || (bus.hitRight && vel_x_q > 0))
            flip_x = -vel_x_q;
        flip_y = vel_y_q;
        if ((bus.hitTop && vel_y_q < 0) || (bus.hitBottom && vel_y_q > 0))
            flip_y = -vel_y_q;

        int_vx   = bus.collisionOccurred ? col_x : flip_x;
        int_vy   = bus.collisionOccurred ? col_y : flip_y;
        nx_pos_x = integ(pos_x_q, int_vx, X_MIN, X_MAX);
        nx_pos_y = integ(pos_y_q, int_vy, Y_MIN, Y_MAX);
    end

    vel_friction #(.FRICTION(FRICTION), .MAX_SPEED(MAX_SPEED)) u_fric_x (
        .vel_i(flip_x), .fric_en_i(1'b1), .vel_o(fr_x)
    );
    vel_friction #(.FRICTION(FRICTION), .MAX_SPEED(MAX_SPEED)) u_fric_y (
        .vel_i(flip_y), .fric_en_i(1'b1), .vel_o(fr_y)
    );

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        acc_d   = 1'b0;
        case (state_q)
            STOPPED: begin
                if (bus.strikeValid) begin
                    vel_x_d = strk_x;
                    vel_y_d = strk_y;
                    acc_d   = 1'b1;
                    state_d = (strk_x != '0 || strk_y != '0) ? MOVING : STOPPED;
                end else if (bus.collisionOccurred &&
                             (bus.ballVelXIn != '0 || bus.ballVelYIn != '0)) begin
                    vel_x_d = col_x;
                    vel_y_d = col_y;
                    state_d = MOVING;
                end
            end
            MOVING: begin
                if (bus.collisionOccurred) begin
                    // Freshly loaded collision velocity skips friction this frame.
                    vel_x_d = col_x;
                    vel_y_d = col_y;
                end else if (bus.startOfFrame) begin
                    vel_x_d = fr_x;
                    vel_y_d = fr_y;
                end else begin
                    vel_x_d = flip_x;
                    vel_y_d = flip_y;
                end
                if (bus.startOfFrame) begin
                    pos_x_d = nx_pos_x;
                    pos_y_d = nx_pos_y;
                end
                if (vel_x_d == '0 && vel_y_d == '0)
                    state_d = STOPPED;
            end
            default: state_d = STOPPED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STOPPED;
            pos_x_q <= PFX_W'(INIT_X << FRAC_BITS);
            pos_y_q <= PFX_W'(INIT_Y << FRAC_BITS);
            vel_x_q <= '0;
            vel_y_q <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.topLeftX       = pos_x_q[PFX_W-1:FRAC_BITS];
    assign bus.topLeftY       = pos_y_q[PFX_W-1:FRAC_BITS];
    assign bus.ballVelX       = vel_x_q;
    assign bus.ballVelY       = vel_y_q;
    assign bus.moving         = (state_q == MOVING);
    assign bus.strikeAccepted = acc_q;
endmodule
